game_input_clkgen: RTL
======================

# game_input_clkgen

Parametrised front end for the 8bitworkshop game wrappers. It generates the game-domain clock and a matching clock-enable strobe from the board clock, with a configurable divide ratio. It also conditions N raw key inputs: polarity normalisation, 2-flop synchroniser and per-key debounce. Press and release events are reported as strobes aligned to the game clock-enable, so a slow game core never misses a key edge. It sits between the board pins and any `*_game_top` core.

## Interface
- `NKEYS`, 4: number of key channels, ≥1.
- `CLK_DIV`, 2: board-clock cycles per game-clock period. Must be even and ≥2.
- `DB_CYCLES`, 4: consecutive stable synchronised cycles required to accept a new key level, ≥1.
- `KEY_ACT_LOW`, 0: 1 = raw keys are active-low and are inverted at the input. 0 = raw keys are active-high.

- `clk`, input, 1: board clock. Single clock domain.
- `reset`, input, 1: asynchronous, active-low reset (0 = reset asserted).
- `keys`, input, NKEYS: raw, asynchronous key pins.
- `clk_div`, output, 1: divided game clock, 50 % duty.
- `clk_en`, output, 1: one-cycle strobe, once per game-clock period.
- `keys_lvl`, output, NKEYS: debounced key levels, active-high.
- `keys_press`, output, NKEYS: press events, valid only while `clk_en`=1.
- `keys_release`, output, NKEYS: release events, valid only while `clk_en`=1.

## Operation
- **Divider.** Counter `div_cnt`, width clog2(CLK_DIV), counts 0..CLK_DIV-1 and wraps to 0.
  - `clk_div` is 1 when `div_cnt` ≥ CLK_DIV/2.
  - `clk_en` is 1 when `div_cnt` = CLK_DIV-1.
  - Both are registered, i.e. flops loaded with the decode of the next count. They are glitch-free.
- **Input stage.** Each key is XORed with KEY_ACT_LOW, then passed through two synchroniser flops. The second flop output is `s[i]`.
- **Debounce (per key).** Counter `db_cnt[i]`, width clog2(DB_CYCLES+1).
  - If `s[i]` == `keys_lvl[i]`: `db_cnt` ← 0.
  - Else if `db_cnt` = DB_CYCLES-1: `keys_lvl[i]` ← `s[i]` and `db_cnt` ← 0.
  - Else: `db_cnt` ← `db_cnt`+1.
  - A disagreement lasting fewer than DB_CYCLES cycles is discarded.
- **Event capture (per key).** There are two sticky flags, `pend_p[i]` and `pend_r[i]`.
  - `pend_p[i]` is set on the edge where `keys_lvl[i]` goes 0→1.
  - `pend_r[i]` is set on the edge where `keys_lvl[i]` goes 1→0.
  - Both flags clear on any edge where `clk_en`=1. If a new set occurs on that same edge, set wins.
  - `keys_press` = `pend_p` & {NKEYS{`clk_en`}}. `keys_release` = `pend_r` & {NKEYS{`clk_en`}}. Both are an AND of flops.
- **Press then release between two strobes.** Both events are reported in the same `clk_en` cycle, and `keys_lvl` shows the final level.
- **Reset.** Assertion clears all state immediately. Clearing mid-debounce or mid-pending drops the event.
  - A key held through reset release is reported as a fresh press once it is debounced.

## Timing
- **Reset values:** `clk_div`=0, `clk_en`=0, `keys_lvl`=0, `keys_press`=0, `keys_release`=0. All internal counters, synchronisers and flags are 0.
- **After reset release:**
  - `clk_div` first rises at rising edge CLK_DIV/2.
  - `clk_en` first asserts at rising edge CLK_DIV-1 and then every CLK_DIV edges.
  - With CLK_DIV=2, `clk_div` toggles on every edge starting at 1, and `clk_en` mirrors `clk_div`.
- **Key latency.** A raw change that is stable before edge k appears on `keys_lvl` after edge k+DB_CYCLES+1, i.e. DB_CYCLES+2 edges including the capture edge.
- **Event latency.** The event strobe appears at the first `clk_en` cycle at or after the `keys_lvl` change. Worst case is CLK_DIV-1 further cycles.
- **Independence.** All channels are independent. Simultaneous edges on multiple keys are reported in the same strobe.

## Test plan
All scenarios use NKEYS=4, CLK_DIV=4, DB_CYCLES=4, KEY_ACT_LOW=0 unless stated.

1. **Reset/divider.** Hold `reset`=0 for 5 cycles, then release. All outputs are 0 during reset. After release, `clk_div` follows 0,0,1,1 repeating, and `clk_en` is high at edges 3, 7, 11.
2. **Debounced press.** Set `keys`=4'b0001, stable before edge k. `keys_lvl[0]` rises after edge k+5. `keys_press`=4'b0001 is asserted for exactly one cycle, at the next `clk_en`, and is 0 elsewhere.
3. **Glitch reject.** Pulse `keys[2]` high for 3 cycles. `keys_lvl` stays 0 and no `keys_press` is generated. A 6-cycle pulse produces both a press and a release.
4. **Press+release inside one period.** With CLK_DIV=16, a 6-cycle key pulse gives `keys_press[1]`=`keys_release[1]`=1 in the same `clk_en` cycle, with `keys_lvl[1]`=0.
5. **Active-low input.** With KEY_ACT_LOW=1 and `keys`=4'b1101, `keys_lvl`=4'b0010 after debounce, and a press is reported for bit 1 only.
6. **Reset mid-operation.** Assert `reset` while `keys[3]` is held and a press is pending. Outputs clear immediately with no strobe. After release, the press is re-reported after the debounce latency plus up to CLK_DIV-1 cycles.

Source files
------------

// File: rtl/game_input_clkgen.sv
// game_input_clkgen: game-clock divider with clock-enable strobe, plus synchronised,
// debounced keys whose press/release events are held until the next clock-enable.
module game_input_clkgen #(
   parameter int NKEYS       = 4,
   parameter int CLK_DIV     = 2,
   parameter int DB_CYCLES   = 4,
   parameter int KEY_ACT_LOW = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NKEYS-1:0] keys,
   output logic             clk_div,
   output logic             clk_en,
   output logic [NKEYS-1:0] keys_lvl,
   output logic [NKEYS-1:0] keys_press,
   output logic [NKEYS-1:0] keys_release
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DB_CYCLES + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
   localparam logic [BW-1:0] DB_LAST = BW'(DB_CYCLES - 1);
   localparam logic [NKEYS-1:0] INV = {NKEYS{KEY_ACT_LOW != 0}};

   logic [DW-1:0]    div_cnt, div_nxt;
   logic [NKEYS-1:0] sync1, s, lvl_nxt, pend_p, pend_r;
   logic [BW-1:0]    db_cnt [NKEYS];
   logic [BW-1:0]    db_nxt [NKEYS];

   assign div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

   // A level is accepted only after DB_CYCLES consecutive disagreeing samples
   always_comb begin
      lvl_nxt = keys_lvl;
      for (int i = 0; i < NKEYS; i++) begin
         db_nxt[i]  = (s[i] == keys_lvl[i] || db_cnt[i] == DB_LAST) ? '0 : db_cnt[i] + 1'b1;
         lvl_nxt[i] = (s[i] != keys_lvl[i] && db_cnt[i] == DB_LAST) ? s[i] : keys_lvl[i];
      end
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         div_cnt  <= '0;
         clk_div  <= 1'b0;
         clk_en   <= 1'b0;
         sync1    <= '0;
         s        <= '0;
         db_cnt   <= '{default: '0};
         keys_lvl <= '0;
         pend_p   <= '0;
         pend_r   <= '0;
      end else begin
         div_cnt  <= div_nxt;
         clk_div  <= div_nxt >= DIV_HALF;
         clk_en   <= div_nxt == DIV_LAST;
         sync1    <= keys ^ INV;
         s        <= sync1;
         db_cnt   <= db_nxt;
         keys_lvl <= lvl_nxt;
         pend_p   <= (pend_p & ~{NKEYS{clk_en}}) | (lvl_nxt & ~keys_lvl);
         pend_r   <= (pend_r & ~{NKEYS{clk_en}}) | (~lvl_nxt & keys_lvl);
      end

   assign keys_press   = pend_p & {NKEYS{clk_en}};
   assign keys_release = pend_r & {NKEYS{clk_en}};
endmodule
